// File: rtl/riscv_defines_pkg.sv
// riscv_defines: core-wide word width, NOP encoding and fetch FSM state type.
package riscv_defines;
  localparam int WORD_WIDTH = 32;
  localparam logic [WORD_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic {FETCH_IDLE, FETCH_REQ} fetch_state_t;
  function automatic logic [WORD_WIDTH-1:0] word_align(input logic [WORD_WIDTH-1:0] a);
    return {a[WORD_WIDTH-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: registered circular buffer with synchronous flush and occupancy count.
module prefetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] count_q;
  logic push, pop;
  assign pop = pop_i && valid_o;
  assign push = push_i && (count_q != (AW+1)'(DEPTH) || pop);
  assign valid_o = count_q != '0;
  assign data_o = mem_q[rptr_q];
  assign count_o = count_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      wptr_q <= wptr_q + AW'(push);
      rptr_q <= rptr_q + AW'(pop);
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush_i) mem_q[wptr_q] <= data_i;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC generation, req/gnt/rvalid fetch and prefetch buffering
// with branch redirect that squashes buffered and in-flight words.
module instr_fetch_unit
  import riscv_defines::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter logic [WORD_WIDTH-1:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en_i,
  input  logic                  branch_i,
  input  logic [WORD_WIDTH-1:0] branch_target_i,
  output logic                  instr_req_o,
  output logic [WORD_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [WORD_WIDTH-1:0] instr_rdata_i,
  output logic                  instr_valid_o,
  output logic [WORD_WIDTH-1:0] instr_o,
  output logic [WORD_WIDTH-1:0] instr_pc_o,
  input  logic                  instr_ready_i,
  output logic                  busy_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_t state_q, state_d;
  logic [WORD_WIDTH-1:0] fetch_pc_q, fetch_pc_d, br_pc_q, br_pc_d, resp_pc_q, resp_pc_d, target;
  logic [CW-1:0] out_q, out_d, disc_q, disc_d, fifo_count, count_d;
  logic br_pend_q, br_pend_d, gnt, stall, push, pop, drop, credit, fifo_valid;
  logic [2*WORD_WIDTH-1:0] fifo_data;
  assign target = word_align(branch_target_i);
  assign instr_req_o = state_q == FETCH_REQ;
  assign instr_addr_o = fetch_pc_q;
  assign gnt = instr_req_o && instr_gnt_i;
  assign stall = instr_req_o && !instr_gnt_i;
  assign drop = instr_rvalid_i && disc_q != '0;
  assign push = instr_rvalid_i && !branch_i && disc_q == '0;
  assign pop = fifo_valid && instr_ready_i && !branch_i;
  // A redirect during a stalled request is parked until that request is granted.
  always_comb begin
    out_d = out_q + CW'(gnt) - CW'(instr_rvalid_i);
    count_d = branch_i ? '0 : fifo_count + CW'(push) - CW'(pop);
    disc_d = branch_i ? out_d : disc_q - CW'(drop) + CW'(gnt && br_pend_q);
    br_pend_d = stall && branch_i ? 1'b1 : gnt ? 1'b0 : br_pend_q;
    br_pc_d = branch_i ? target : br_pc_q;
    fetch_pc_d = branch_i && !stall ? target
               : gnt ? (br_pend_q ? br_pc_q : fetch_pc_q + WORD_WIDTH'(4)) : fetch_pc_q;
    resp_pc_d = branch_i ? target : push ? resp_pc_q + WORD_WIDTH'(4) : resp_pc_q;
    credit = fetch_en_i && ({1'b0, out_d} + {1'b0, count_d} < (CW+1)'(FIFO_DEPTH));
    state_d = stall || credit ? FETCH_REQ : FETCH_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH_IDLE;
      fetch_pc_q <= BOOT_ADDR;
      br_pc_q <= '0;
      br_pend_q <= 1'b0;
      resp_pc_q <= BOOT_ADDR;
      out_q <= '0;
      disc_q <= '0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      br_pc_q <= br_pc_d;
      br_pend_q <= br_pend_d;
      resp_pc_q <= resp_pc_d;
      out_q <= out_d;
      disc_q <= disc_d;
    end
  end
  prefetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(2*WORD_WIDTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (branch_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  ({instr_rdata_i, resp_pc_q}),
    .valid_o (fifo_valid),
    .data_o  (fifo_data),
    .count_o (fifo_count)
  );
  assign instr_valid_o = fifo_valid;
  assign instr_o = fifo_valid ? fifo_data[2*WORD_WIDTH-1:WORD_WIDTH] : NOP_INSTR;
  assign instr_pc_o = fifo_valid ? fifo_data[WORD_WIDTH-1:0] : '0;
  assign busy_o = out_q != '0 || fifo_valid || instr_req_o;
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch stage of the ri5cy-flavoured core: generates PCs, issues word reads on the instruction-memory request/grant/rvalid interface and buffers returned words in a small prefetch FIFO. It is the producer feeding instruction_i of the control unit (decoder + controller), via a valid/ready handshake. It handles taken-branch/jump redirects by flushing buffered and in-flight fetches.

Parameters:
FIFO_DEPTH, 2, prefetch entries (power of 2, >=2); also the maximum number of outstanding plus buffered fetches.
BOOT_ADDR, 32'h0000_0080, first fetch address after reset.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
fetch_en_i  in  1  fetching permitted; when low, no new requests are issued
branch_i  in  1  redirect strobe (taken branch/jump)
branch_target_i  in  WORD_WIDTH  redirect address; bits [1:0] ignored
instr_req_o  out  1  memory request
instr_addr_o  out  WORD_WIDTH  request address, word aligned
instr_gnt_i  in  1  request accepted this cycle
instr_rvalid_i  in  1  read data valid, in order, at least 1 cycle after gnt
instr_rdata_i  in  WORD_WIDTH  read data
instr_valid_o  out  1  instr_o/instr_pc_o valid
instr_o  out  WORD_WIDTH  instruction to control_unit instruction_i
instr_pc_o  out  WORD_WIDTH  PC of instr_o
instr_ready_i  in  1  decode accepts instruction this cycle
busy_o  out  1  outstanding requests or non-empty FIFO

Behaviour:
- Reset values: instr_req_o=0, instr_addr_o=BOOT_ADDR, instr_valid_o=0, instr_o=32'h0000_0013 (NOP), instr_pc_o=0, busy_o=0. FIFO is empty, the outstanding counter is 0 and the discard counter is 0.
- FSM states:
  - IDLE: req=0. Go to REQ when fetch_en_i=1 and (outstanding + fifo_count) < FIFO_DEPTH.
  - REQ: req=1 and addr is held stable until gnt. On gnt: fetch_pc += 4 (wraps modulo 2^32) and outstanding++. Stay in REQ if the credit condition still holds after this grant, else go to IDLE.
- req, once raised, is never withdrawn before gnt, even if fetch_en_i falls or branch_i arrives.
- On rvalid: outstanding--. If discard>0, discard-- and drop the data. Otherwise push {rdata, pc} into the FIFO; the tracked response PC advances by 4.
- FIFO output is registered, with no bypass: data returned with rvalid at cycle N is visible on instr_valid_o at N+1.
- instr_valid_o = FIFO not empty. A pop occurs when instr_valid_o && instr_ready_i. Push and pop in the same cycle on a full FIFO is legal, and the count is unchanged.
- Branch (branch_i=1 in cycle N):
  - The FIFO is cleared at N+1.
  - discard := outstanding, plus 1 if a gnt occurs in cycle N.
  - rvalid data in cycle N is dropped.
  - fetch_pc := {branch_target_i[31:2], 2'b00}.
  - If req was pending without gnt, that request completes at its old address and its response is discarded. The target request follows.
  - If idle, req with the target address asserts at N+1.
  - branch_i takes priority over a simultaneous pop, push or gnt bookkeeping. instr_valid_o=0 at N+1.
- Back-to-back branches: the last one wins, and discard accumulates correctly.
- Credit rule: outstanding + fifo_count + discard never admits a response without FIFO space. Discarded responses do not need slots.
- Memory stalls (gnt low indefinitely) hold req/addr with no other side effects.
- Asynchronous reset mid-transaction returns to the reset values immediately. Any late rvalid after reset is the environment's responsibility and is not tracked.
- busy_o = (outstanding != 0) || FIFO not empty || instr_req_o.

Decomposition:
- Shared riscv_defines package: WORD_WIDTH, NOP_INSTR (32'h0000_0013), and the fetch FSM state enum typedef fetch_state_t.
- One sub-module: prefetch_fifo (parameterised depth/width, sync push/pop/flush, count output). The FSM, PC and counters live in instr_fetch_unit.

Test Plan:
- Reset then fetch_en_i=1, memory with gnt same cycle and rvalid +1, ready=1: addresses 0x80, 0x84, 0x88 are issued. instr_o/instr_pc_o stream the matching words with instr_pc_o = 0x80, 0x84, 0x88, and the first instr_valid_o appears 3 cycles after rst_n rises plus the request cycle.
- instr_ready_i=0 with FIFO_DEPTH=2: exactly 2 words are fetched, then req stays 0. Raising ready restarts fetching without loss or duplication of PC 0x88.
- Branch to 0x1002 while 2 fetches are outstanding: both responses are dropped, the next request address is 0x1000, and the first valid instr_pc_o is 0x1000.
- gnt held low 5 cycles, then a branch to 0x200 during the stall: addr stays stable until gnt, that response is discarded, and the next request is 0x200.
- Branch in the same cycle as rvalid and a pop: no stale instruction appears on instr_o. The next valid instruction is the target.
- fetch_pc at 0xFFFF_FFFC: the next request wraps to 0x0000_0000. Asserting rst_n=0 mid-request drops req immediately and sets addr to 0x80.
